// File: rtl/hamming_secded_decode_pipe.sv
// Two-stage SECDED Hamming decoder with valid/ready flow control on both sides.
// Keeps saturating correctable/uncorrectable counters and a sticky first-error capture.
module hamming_secded_decode_pipe #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int COUNT_WIDTH = 16,
    localparam int ADDR_WIDTH  = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1),
    localparam int CODED_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CODED_WIDTH-1:0] in_code,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [1:0]             out_err,
    output logic [ADDR_WIDTH-1:0]  out_loc,
    input  logic                   cnt_clr,
    output logic [COUNT_WIDTH-1:0] corr_cnt,
    output logic [COUNT_WIDTH-1:0] uncorr_cnt,
    output logic                   first_vld,
    output logic [1:0]             first_err,
    output logic [ADDR_WIDTH-1:0]  first_loc
);

    // Codeword index of payload bit k: the k-th non-power-of-2 index at or above 3.
    function automatic int f_data_pos(input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 3; i < CODED_WIDTH; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == k) pos = i;
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

    logic [ADDR_WIDTH-1:0]  w_syn;
    logic                   w_par;
    logic [DATA_WIDTH-1:0]  w_in_data;
    logic                   w_s2_ready;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_syn_in_range;
    logic [1:0]             w_err;
    logic [DATA_WIDTH-1:0]  w_fix_data;

    logic                   r_s1_valid;
    logic [DATA_WIDTH-1:0]  r_s1_data;
    logic [ADDR_WIDTH-1:0]  r_s1_syn;
    logic                   r_s1_par;

    logic                   r_s2_valid;
    logic [DATA_WIDTH-1:0]  r_s2_data;
    logic [1:0]             r_s2_err;
    logic [ADDR_WIDTH-1:0]  r_s2_loc;

    logic [COUNT_WIDTH-1:0] r_corr_cnt;
    logic [COUNT_WIDTH-1:0] r_uncorr_cnt;
    logic                   r_first_vld;
    logic [1:0]             r_first_err;
    logic [ADDR_WIDTH-1:0]  r_first_loc;

    always_comb begin
        w_syn = '0;
        for (int i = 0; i < CODED_WIDTH; i++) begin
            if (in_code[i]) w_syn = w_syn ^ ADDR_WIDTH'(i);
        end
    end

    assign w_par = ^in_code;

    // Only payload bits are carried forward; the check bits are fully summarised by S and P.
    for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_data
        localparam int POS = f_data_pos(k);
        assign w_in_data[k]  = in_code[POS];
        assign w_fix_data[k] = r_s1_data[k] ^
                               ((w_err == 2'b01) && (r_s1_syn == ADDR_WIDTH'(POS)));
    end

    assign w_syn_in_range = ({1'b0, r_s1_syn} < (ADDR_WIDTH + 1)'(CODED_WIDTH));

    always_comb begin
        w_err = 2'b00;
        if (r_s1_par) begin
            w_err = w_syn_in_range ? 2'b01 : 2'b11;
        end else if (r_s1_syn != '0) begin
            w_err = 2'b10;
        end
    end

    assign w_s2_ready = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_s2_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_syn   <= '0;
            r_s1_par   <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (w_in_fire) begin
                r_s1_data <= w_in_data;
                r_s1_syn  <= w_syn;
                r_s1_par  <= w_par;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_err   <= 2'b00;
            r_s2_loc   <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_fix_data;
                r_s2_err  <= w_err;
                r_s2_loc  <= r_s1_syn;
            end
        end
    end

    // A clear in the same cycle as an accepted error wipes first, then records that word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
            r_first_vld  <= 1'b0;
            r_first_err  <= 2'b00;
            r_first_loc  <= '0;
        end else begin
            if (cnt_clr) begin
                r_corr_cnt   <= '0;
                r_uncorr_cnt <= '0;
                r_first_vld  <= 1'b0;
                r_first_err  <= 2'b00;
                r_first_loc  <= '0;
            end
            if (w_out_fire) begin
                if (r_s2_err == 2'b01) begin
                    if (cnt_clr) begin
                        r_corr_cnt <= COUNT_WIDTH'(1);
                    end else if (r_corr_cnt != '1) begin
                        r_corr_cnt <= r_corr_cnt + COUNT_WIDTH'(1);
                    end
                end
                if (r_s2_err[1]) begin
                    if (cnt_clr) begin
                        r_uncorr_cnt <= COUNT_WIDTH'(1);
                    end else if (r_uncorr_cnt != '1) begin
                        r_uncorr_cnt <= r_uncorr_cnt + COUNT_WIDTH'(1);
                    end
                end
                if ((r_s2_err != 2'b00) && (cnt_clr || !r_first_vld)) begin
                    r_first_vld <= 1'b1;
                    r_first_err <= r_s2_err;
                    r_first_loc <= r_s2_loc;
                end
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_data   = r_s2_data;
    assign out_err    = r_s2_err;
    assign out_loc    = r_s2_loc;
    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;
    assign first_vld  = r_first_vld;
    assign first_err  = r_first_err;
    assign first_loc  = r_first_loc;

endmodule

// File: tb/tb_hamming_secded_decode_pipe.sv
// Directed bench for the SECDED decoder at DATA_WIDTH=8 (13-bit codewords).
// Instance A has wide counters; instance B uses 2-bit counters for saturation and reset cases.
module tb_hamming_secded_decode_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cnt_clr;
    logic [12:0] a_in_code;
    logic [7:0]  a_out_data;
    logic [1:0]  a_out_err, a_first_err;
    logic [3:0]  a_out_loc, a_first_loc;
    logic [15:0] a_corr_cnt, a_uncorr_cnt;
    logic        a_first_vld;

    logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cnt_clr;
    logic [12:0] b_in_code;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_err, b_first_err;
    logic [3:0]  b_out_loc, b_first_loc;
    logic [1:0]  b_corr_cnt, b_uncorr_cnt;
    logic        b_first_vld;

    hamming_secded_decode_pipe #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) u_dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_code(a_in_code), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_err(a_out_err), .out_loc(a_out_loc),
        .cnt_clr(a_cnt_clr), .corr_cnt(a_corr_cnt), .uncorr_cnt(a_uncorr_cnt),
        .first_vld(a_first_vld), .first_err(a_first_err), .first_loc(a_first_loc)
    );

    hamming_secded_decode_pipe #(.DATA_WIDTH(8), .COUNT_WIDTH(2)) u_dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_code(b_in_code), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_err(b_out_err), .out_loc(b_out_loc),
        .cnt_clr(b_cnt_clr), .corr_cnt(b_corr_cnt), .uncorr_cnt(b_uncorr_cnt),
        .first_vld(b_first_vld), .first_err(b_first_err), .first_loc(b_first_loc)
    );

    typedef struct {
        logic [12:0] code;
        logic [7:0]  data;
        logic [1:0]  err;
        logic [3:0]  loc;
    } vec_t;

    vec_t vecs[12];
    vec_t stall_v[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One word in, then sample 1 time unit after the second rising edge.
    task automatic a_apply(input logic [12:0] code);
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_code  = code;
        @(negedge clk);
        a_in_valid = 1'b0;
        a_in_code  = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic b_send(input logic [12:0] code);
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_code  = code;
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_code  = '0;
    endtask

    initial begin
        int  acc;
        int  got;
        logic fire_in;
        logic fire_out;
        logic seen;

        vecs[0]  = '{13'h000F, 8'h01, 2'b00, 4'd0};
        vecs[1]  = '{13'h0020, 8'h00, 2'b01, 4'd5};
        vecs[2]  = '{13'h0028, 8'h03, 2'b10, 4'd6};
        vecs[3]  = '{13'h1006, 8'h80, 2'b11, 4'd15};
        vecs[4]  = '{13'h0001, 8'h00, 2'b01, 4'd0};
        vecs[5]  = '{13'h1EEE, 8'hFF, 2'b00, 4'd0};
        vecs[6]  = '{13'h164E, 8'hA5, 2'b01, 4'd9};
        vecs[7]  = '{13'h16C5, 8'h3C, 2'b01, 4'd12};
        vecs[8]  = '{13'h1EEA, 8'hFF, 2'b01, 4'd2};
        vecs[9]  = '{13'h144D, 8'hA5, 2'b10, 4'd1};
        vecs[10] = '{13'h07D1, 8'h3C, 2'b11, 4'd14};
        vecs[11] = '{13'h0000, 8'h00, 2'b00, 4'd0};

        stall_v[0] = '{13'h164E, 8'hA5, 2'b01, 4'd9};
        stall_v[1] = '{13'h0020, 8'h00, 2'b01, 4'd5};
        stall_v[2] = '{13'h16C5, 8'h3C, 2'b01, 4'd12};
        stall_v[3] = '{13'h0028, 8'h03, 2'b10, 4'd6};

        a_rst = 1'b1; a_in_valid = 1'b0; a_in_code = '0; a_out_ready = 1'b1; a_cnt_clr = 1'b0;
        b_rst = 1'b1; b_in_valid = 1'b0; b_in_code = '0; b_out_ready = 1'b1; b_cnt_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_corr_cnt", a_corr_cnt, 0);
        chk("rst_uncorr_cnt", a_uncorr_cnt, 0);
        chk("rst_first_vld", a_first_vld, 0);
        @(negedge clk);
        a_rst = 1'b0;
        b_rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            a_apply(vecs[i].code);
            chk($sformatf("vec%0d_valid", i), a_out_valid, 1);
            chk($sformatf("vec%0d_data", i), a_out_data, vecs[i].data);
            chk($sformatf("vec%0d_err", i), a_out_err, vecs[i].err);
            chk($sformatf("vec%0d_loc", i), a_out_loc, vecs[i].loc);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("tbl_corr_cnt", a_corr_cnt, 5);
        chk("tbl_uncorr_cnt", a_uncorr_cnt, 4);
        chk("tbl_first_vld", a_first_vld, 1);
        chk("tbl_first_err", a_first_err, 1);
        chk("tbl_first_loc", a_first_loc, 5);

        @(negedge clk);
        a_cnt_clr = 1'b1;
        @(negedge clk);
        a_cnt_clr = 1'b0;
        #1;
        chk("clr_corr_cnt", a_corr_cnt, 0);
        chk("clr_uncorr_cnt", a_uncorr_cnt, 0);
        chk("clr_first_vld", a_first_vld, 0);

        // Backpressure: out_ready low for the first 5 cycles while 4 words are offered.
        acc = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            a_out_ready = (cyc >= 5);
            a_in_valid  = (acc < 4);
            if (acc < 4) a_in_code = stall_v[acc].code;
            #1;
            if (cyc == 4) begin
                chk("stall_in_ready", a_in_ready, 0);
                chk("stall_accepted", acc, 2);
            end
            if (cyc >= 2 && cyc < 5) begin
                chk("stall_hold_valid", a_out_valid, 1);
                chk("stall_hold_data", a_out_data, stall_v[0].data);
                chk("stall_hold_loc", a_out_loc, stall_v[0].loc);
            end
            fire_in  = a_in_valid && a_in_ready;
            fire_out = a_out_valid && a_out_ready;
            if (fire_out) begin
                chk($sformatf("drain%0d_data", got), a_out_data, stall_v[got].data);
                chk($sformatf("drain%0d_err", got), a_out_err, stall_v[got].err);
                chk($sformatf("drain%0d_loc", got), a_out_loc, stall_v[got].loc);
                got++;
            end
            @(posedge clk);
            if (fire_in) acc++;
        end
        chk("stall_drained", got, 4);
        @(negedge clk);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        #1;
        chk("stall_corr_cnt", a_corr_cnt, 3);
        chk("stall_uncorr_cnt", a_uncorr_cnt, 1);
        chk("stall_first_err", a_first_err, 1);
        chk("stall_first_loc", a_first_loc, 9);
        repeat (2) @(posedge clk);
        #1;
        chk("stall_no_dup", a_corr_cnt, 3);

        // Saturation on the 2-bit counter instance.
        for (int i = 0; i < 5; i++) b_send(13'h0020);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_corr_cnt", b_corr_cnt, 3);
        chk("sat_uncorr_cnt", b_uncorr_cnt, 0);
        chk("sat_first_loc", b_first_loc, 5);

        // Clear coinciding with an accepted corrected word: clear first, then count and capture.
        b_send(13'h164E);
        @(posedge clk);
        @(negedge clk);
        chk("clrhit_out_valid", b_out_valid, 1);
        b_cnt_clr = 1'b1;
        @(negedge clk);
        b_cnt_clr = 1'b0;
        #1;
        chk("clrhit_corr_cnt", b_corr_cnt, 1);
        chk("clrhit_first_vld", b_first_vld, 1);
        chk("clrhit_first_loc", b_first_loc, 9);

        // Reset with both stages full.
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_code  = 13'h16C5;
        @(negedge clk);
        b_in_code  = 13'h1EEE;
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_code  = '0;
        #1;
        chk("mid_pre_valid", b_out_valid, 1);
        chk("mid_pre_data", b_out_data, 8'h3C);
        b_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", b_out_valid, 0);
        chk("mid_rst_out_data", b_out_data, 0);
        chk("mid_rst_out_err", b_out_err, 0);
        chk("mid_rst_out_loc", b_out_loc, 0);
        chk("mid_rst_corr_cnt", b_corr_cnt, 0);
        chk("mid_rst_uncorr_cnt", b_uncorr_cnt, 0);
        chk("mid_rst_first_vld", b_first_vld, 0);
        chk("mid_rst_first_err", b_first_err, 0);
        chk("mid_rst_first_loc", b_first_loc, 0);
        chk("mid_rst_in_ready", b_in_ready, 1);
        @(negedge clk);
        b_rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (b_out_valid) seen = 1'b1;
        end
        chk("mid_rst_discarded", seen, 0);
        chk("mid_rst_cnt_after", b_corr_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
